// File: rtl/memory_injector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_injector_pkg
// Purpose  : Shared types, constants and the expected-data generator used by
//            the read response checker.
// Contents : checker_state_t  - IDLE / RUNNING / HALTED
//            COUNTER_WIDTH    - width of the saturating event counters
//            wide_word_t      - fixed-width carrier for expected_data()
//            expected_data()  - address/seed -> replicated data pattern
// Revision : 1.0 - initial release
// ============================================================================
package memory_injector_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    HALTED  = 2'd2
  } checker_state_t;

  localparam int COUNTER_WIDTH = 32;

  // Widest address or data the generator supports. Callers zero-extend their
  // operands into this width and use the low bits of the result.
  localparam int EXPECTED_MAX_WIDTH = 256;

  typedef logic [EXPECTED_MAX_WIDTH-1:0] wide_word_t;

  // pattern = address ^ seed, replicated from bit 0 upwards so that result
  // bit i equals pattern bit (i mod address_width).
  function automatic wide_word_t expected_data(
    input wide_word_t address,
    input wide_word_t seed,
    input int         address_width
  );
    wide_word_t pattern;
    wide_word_t result;
    pattern = address ^ seed;
    result  = '0;
    for (int i = 0; i < EXPECTED_MAX_WIDTH; i++) begin
      result[i] = pattern[i % address_width];
    end
    return result;
  endfunction

endpackage : memory_injector_pkg
`default_nettype wire

// File: rtl/read_response_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : read_response_checker_if
// Purpose  : Request/response handshake bundle between the traffic source
//            (address generator + memory under test) and the checker.
// Signals  : request_valid/address/ready   - issued read addresses
//            response_valid/data/ready     - read responses
// Modports : master - traffic source, slave - checker
// Revision : 1.0 - initial release
// ============================================================================
interface read_response_checker_if #(
  parameter int ADDRESS_WIDTH = 48,
  parameter int DATA_WIDTH    = 64
);

  logic                     request_valid;
  logic [ADDRESS_WIDTH-1:0] request_address;
  logic                     request_ready;
  logic                     response_valid;
  logic [DATA_WIDTH-1:0]    response_data;
  logic                     response_ready;

  modport master (
    output request_valid,
    output request_address,
    input  request_ready,
    output response_valid,
    output response_data,
    input  response_ready
  );

  modport slave (
    input  request_valid,
    input  request_address,
    output request_ready,
    input  response_valid,
    input  response_data,
    output response_ready
  );

endinterface : read_response_checker_if
`default_nettype wire

// File: rtl/synchronous_fifo.sv
`default_nettype none
// ============================================================================
// Module   : synchronous_fifo
// Purpose  : Generic single-clock FIFO with occupancy count and first-word
//            fall-through head.
// Ports    : clock_i, resetn_i (async active-low), clear_i (sync flush)
//            push_i/push_data_i  - write (ignored when full)
//            pop_i               - read  (ignored when empty)
//            head_o              - oldest entry
//            full_o, empty_o, count_o (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module synchronous_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  wire logic                       clock_i,
  input  wire logic                       resetn_i,
  input  wire logic                       clear_i,
  input  wire logic                       push_i,
  input  wire logic [WIDTH-1:0]           push_data_i,
  input  wire logic                       pop_i,
  output logic      [WIDTH-1:0]           head_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic      [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_WIDTH   = $clog2(DEPTH);
  localparam int COUNT_WIDTH = $clog2(DEPTH+1);

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_q;
  logic [PTR_WIDTH-1:0]   rd_ptr_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic w_push;
  logic w_pop;

  assign full_o  = (count_q == COUNT_WIDTH'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i  && !empty_o;

  // Storage needs no reset: occupancy guards every read.
  always_ff @(posedge clock_i) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers are log2(DEPTH) bits and wrap naturally for power-of-two DEPTH.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + COUNT_WIDTH'(1);
        2'b01:   count_q <= count_q - COUNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : synchronous_fifo
`default_nettype wire

// File: rtl/read_response_checker.sv
`default_nettype none
// ============================================================================
// Module   : read_response_checker
// Purpose  : Matches each read response to the oldest outstanding read
//            address and compares it against the data pattern the injector
//            wrote there. Counts checks and mismatches and captures the
//            first mismatch.
// Ports    : clock_i, resetn_i (async active-low), initialize_i (sync clear)
//            enable_i, stop_on_error_i, data_seed_i, compare_mask_i
//            check_if (slave)   - request and response handshakes
//            outstanding_count_o, checked_count_o, error_count_o
//            first_error_valid_o/address_o/data_o, halted_o
// Revision : 1.0 - initial release
// ============================================================================
module read_response_checker
  import memory_injector_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 48,
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH         = 16
) (
  input  wire logic                       clock_i,
  input  wire logic                       resetn_i,
  input  wire logic                       initialize_i,
  input  wire logic                       enable_i,
  input  wire logic                       stop_on_error_i,
  input  wire logic [ADDRESS_WIDTH-1:0]   data_seed_i,
  input  wire logic [DATA_WIDTH-1:0]      compare_mask_i,
  read_response_checker_if.slave          check_if,
  output logic [$clog2(DEPTH+1)-1:0]      outstanding_count_o,
  output logic [COUNTER_WIDTH-1:0]        checked_count_o,
  output logic [COUNTER_WIDTH-1:0]        error_count_o,
  output logic                            first_error_valid_o,
  output logic [ADDRESS_WIDTH-1:0]        first_error_address_o,
  output logic [DATA_WIDTH-1:0]           first_error_data_o,
  output logic                            halted_o
);

  checker_state_t           state_q;
  logic [COUNTER_WIDTH-1:0] checked_count_q, checked_count_d;
  logic [COUNTER_WIDTH-1:0] error_count_q,   error_count_d;
  logic                     first_error_valid_q,   first_error_valid_d;
  logic [ADDRESS_WIDTH-1:0] first_error_address_q, first_error_address_d;
  logic [DATA_WIDTH-1:0]    first_error_data_q,    first_error_data_d;

  logic [ADDRESS_WIDTH-1:0] w_head;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_accept;
  logic                     w_mismatch;
  wide_word_t               w_head_wide;
  wide_word_t               w_seed_wide;
  wide_word_t               w_data_wide;
  wide_word_t               w_mask_wide;
  wide_word_t               w_expected_wide;

  // Readies are decoded from the registered state so that HALTED and IDLE
  // freeze the FIFO without any extra gating.
  assign check_if.request_ready  = (state_q == RUNNING) && !w_full;
  assign check_if.response_ready = (state_q == RUNNING) && !w_empty;

  assign w_push   = check_if.request_valid  && check_if.request_ready;
  assign w_accept = check_if.response_valid && check_if.response_ready;

  synchronous_fifo #(
    .WIDTH (ADDRESS_WIDTH),
    .DEPTH (DEPTH)
  ) u_outstanding_fifo (
    .clock_i     (clock_i),
    .resetn_i    (resetn_i),
    .clear_i     (initialize_i),
    .push_i      (w_push),
    .push_data_i (check_if.request_address),
    .pop_i       (w_accept),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (outstanding_count_o)
  );

  // Everything is widened to the generator width. The mask is zero above
  // DATA_WIDTH, so the upper expected bits never influence the result.
  always_comb begin
    w_head_wide = '0;
    w_seed_wide = '0;
    w_data_wide = '0;
    w_mask_wide = '0;
    w_head_wide[ADDRESS_WIDTH-1:0] = w_head;
    w_seed_wide[ADDRESS_WIDTH-1:0] = data_seed_i;
    w_data_wide[DATA_WIDTH-1:0]    = check_if.response_data;
    w_mask_wide[DATA_WIDTH-1:0]    = compare_mask_i;
    w_expected_wide = expected_data(w_head_wide, w_seed_wide, ADDRESS_WIDTH);
    w_mismatch      = |((w_expected_wide ^ w_data_wide) & w_mask_wide);
  end

  // Counter and capture next-state; counters saturate rather than wrap.
  always_comb begin
    checked_count_d       = checked_count_q;
    error_count_d         = error_count_q;
    first_error_valid_d   = first_error_valid_q;
    first_error_address_d = first_error_address_q;
    first_error_data_d    = first_error_data_q;
    if (w_accept) begin
      if (checked_count_q != '1) begin
        checked_count_d = checked_count_q + COUNTER_WIDTH'(1);
      end
      if (w_mismatch) begin
        if (error_count_q != '1) begin
          error_count_d = error_count_q + COUNTER_WIDTH'(1);
        end
        if (!first_error_valid_q) begin
          first_error_valid_d   = 1'b1;
          first_error_address_d = w_head;
          first_error_data_d    = check_if.response_data;
        end
      end
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q               <= IDLE;
      checked_count_q       <= '0;
      error_count_q         <= '0;
      first_error_valid_q   <= 1'b0;
      first_error_address_q <= '0;
      first_error_data_q    <= '0;
    end else if (initialize_i) begin
      state_q               <= IDLE;
      checked_count_q       <= '0;
      error_count_q         <= '0;
      first_error_valid_q   <= 1'b0;
      first_error_address_q <= '0;
      first_error_data_q    <= '0;
    end else begin
      checked_count_q       <= checked_count_d;
      error_count_q         <= error_count_d;
      first_error_valid_q   <= first_error_valid_d;
      first_error_address_q <= first_error_address_d;
      first_error_data_q    <= first_error_data_d;
      case (state_q)
        IDLE: begin
          if (enable_i) begin
            state_q <= RUNNING;
          end
        end
        RUNNING: begin
          // A halting mismatch wins over a simultaneous enable drop.
          if (w_accept && w_mismatch && stop_on_error_i) begin
            state_q <= HALTED;
          end else if (!enable_i) begin
            state_q <= IDLE;
          end
        end
        HALTED:  state_q <= HALTED;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign checked_count_o       = checked_count_q;
  assign error_count_o         = error_count_q;
  assign first_error_valid_o   = first_error_valid_q;
  assign first_error_address_o = first_error_address_q;
  assign first_error_data_o    = first_error_data_q;
  assign halted_o              = (state_q == HALTED);

endmodule : read_response_checker
`default_nettype wire

// File: tb/tb_read_response_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_read_response_checker
// Purpose  : Self-checking bench for read_response_checker. A queue-based
//            model predicts every output each cycle; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_read_response_checker;

  localparam int AW    = 48;
  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clock         = 1'b0;
  logic          resetn        = 1'b0;
  logic          initialize    = 1'b0;
  logic          enable        = 1'b0;
  logic          stop_on_error = 1'b0;
  logic [AW-1:0] data_seed     = '0;
  logic [DW-1:0] compare_mask  = '1;

  logic [CW-1:0] outstanding_count;
  logic [31:0]   checked_count;
  logic [31:0]   error_count;
  logic          first_error_valid;
  logic [AW-1:0] first_error_address;
  logic [DW-1:0] first_error_data;
  logic          halted;

  read_response_checker_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  read_response_checker #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH)
  ) dut (
    .clock_i               (clock),
    .resetn_i              (resetn),
    .initialize_i          (initialize),
    .enable_i              (enable),
    .stop_on_error_i       (stop_on_error),
    .data_seed_i           (data_seed),
    .compare_mask_i        (compare_mask),
    .check_if              (bus.slave),
    .outstanding_count_o   (outstanding_count),
    .checked_count_o       (checked_count),
    .error_count_o         (error_count),
    .first_error_valid_o   (first_error_valid),
    .first_error_address_o (first_error_address),
    .first_error_data_o    (first_error_data),
    .halted_o              (halted)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {pattern[15:0], pattern[47:0]} for the 48/64 configuration.
  function automatic logic [DW-1:0] expected_of(input logic [AW-1:0] a, input logic [AW-1:0] s);
    logic [AW-1:0] p;
    p = a ^ s;
    return {p[15:0], p};
  endfunction

  // ---------------------------------------------------------------- model
  int            m_state;   // 0 idle, 1 running, 2 halted
  logic [AW-1:0] m_q[$];
  logic [31:0]   m_checked;
  logic [31:0]   m_errors;
  logic          m_fev;
  logic [AW-1:0] m_fea;
  logic [DW-1:0] m_fed;

  task automatic model_clear();
    m_state   = 0;
    m_q.delete();
    m_checked = '0;
    m_errors  = '0;
    m_fev     = 1'b0;
    m_fea     = '0;
    m_fed     = '0;
  endtask

  function automatic bit m_req_ready();
    return (m_state == 1) && (m_q.size() < DEPTH);
  endfunction

  function automatic bit m_rsp_ready();
    return (m_state == 1) && (m_q.size() > 0);
  endfunction

  // Advances the model by the clock edge that will sample the current inputs.
  task automatic model_step();
    bit            do_push, do_pop, mis;
    logic [AW-1:0] head;
    if (initialize) begin
      model_clear();
      return;
    end
    do_push = bus.request_valid  && m_req_ready();
    do_pop  = bus.response_valid && m_rsp_ready();
    mis     = 1'b0;
    if (do_pop) begin
      head = m_q.pop_front();
      mis  = |((bus.response_data ^ expected_of(head, data_seed)) & compare_mask);
      if (m_checked != 32'hFFFF_FFFF) m_checked++;
      if (mis) begin
        if (m_errors != 32'hFFFF_FFFF) m_errors++;
        if (!m_fev) begin
          m_fev = 1'b1;
          m_fea = head;
          m_fed = bus.response_data;
        end
      end
    end
    if (do_push) m_q.push_back(bus.request_address);
    case (m_state)
      0: if (enable) m_state = 1;
      1: begin
        if (do_pop && mis && stop_on_error) m_state = 2;
        else if (!enable) m_state = 0;
      end
      default: m_state = 2;
    endcase
  endtask

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clock) begin
    if (!resetn) model_clear();
    chk("request_ready",       bus.request_ready,   m_req_ready());
    chk("response_ready",      bus.response_ready,  m_rsp_ready());
    chk("outstanding_count",   outstanding_count,   m_q.size());
    chk("checked_count",       checked_count,       m_checked);
    chk("error_count",         error_count,         m_errors);
    chk("first_error_valid",   first_error_valid,   m_fev);
    chk("first_error_address", first_error_address, m_fea);
    chk("first_error_data",    first_error_data,    m_fed);
    chk("halted",              halted,              m_state == 2);
    if (resetn) model_step();
  end

  // --------------------------------------------------------------- driver
  logic [AW-1:0] drv_q[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_addr(input logic [AW-1:0] a);
    bit done = 1'b0;
    bus.request_valid   = 1'b1;
    bus.request_address = a;
    for (int k = 0; k < 64 && !done; k++) begin
      if (bus.request_ready) begin
        done = 1'b1;
        drv_q.push_back(a);
      end
      tick();
    end
    bus.request_valid = 1'b0;
    if (!done) chk("push_timeout", 64'd1, 64'd0);
  endtask

  task automatic respond_data(input logic [DW-1:0] d);
    bit done = 1'b0;
    bus.response_valid = 1'b1;
    bus.response_data  = d;
    for (int k = 0; k < 64 && !done; k++) begin
      if (bus.response_ready) begin
        done = 1'b1;
        void'(drv_q.pop_front());
      end
      tick();
    end
    bus.response_valid = 1'b0;
    if (!done) chk("response_timeout", 64'd1, 64'd0);
  endtask

  task automatic respond(input logic [DW-1:0] flip);
    respond_data(expected_of(drv_q[0], data_seed) ^ flip);
  endtask

  task automatic push_pop(input logic [AW-1:0] a);
    bus.request_valid   = 1'b1;
    bus.request_address = a;
    bus.response_valid  = 1'b1;
    bus.response_data   = expected_of(drv_q[0], data_seed);
    chk("push_pop_readies", {bus.request_ready, bus.response_ready}, 2'b11);
    tick();
    void'(drv_q.pop_front());
    drv_q.push_back(a);
    bus.request_valid  = 1'b0;
    bus.response_valid = 1'b0;
  endtask

  task automatic pulse_init();
    initialize = 1'b1;
    tick();
    initialize = 1'b0;
    drv_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.request_valid   = 1'b0;
    bus.request_address = '0;
    bus.response_valid  = 1'b0;
    bus.response_data   = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outstanding", outstanding_count, 0);
    chk("reset_checked",     checked_count,     0);
    chk("reset_errvalid",    first_error_valid, 0);
    chk("reset_halted",      halted,            0);
    chk("reset_req_ready",   bus.request_ready, 0);
    resetn = 1'b1;
    enable = 1'b1;
    tick();

    // Basic: seed 0, three correct responses in order.
    push_addr(48'h0);
    push_addr(48'h8);
    push_addr(48'h10);
    repeat (3) respond('0);
    tick();
    chk("basic_checked",     checked_count,     3);
    chk("basic_errors",      error_count,       0);
    chk("basic_outstanding", outstanding_count, 0);

    // Expected-data format: 0x40 ^ 0x123456789ABC = 0x123456789AFC.
    pulse_init();
    data_seed = 48'h1234_5678_9ABC;
    tick();
    chk("model_pattern", expected_of(48'h40, data_seed), 64'h9AFC_1234_5678_9AFC);
    push_addr(48'h40);
    respond_data(64'h9AFC_1234_5678_9AFC);
    compare_mask[0] = 1'b0;
    push_addr(48'h40);
    respond_data(64'h9AFC_1234_5678_9AFD);
    tick();
    compare_mask = '1;
    chk("format_errors",  error_count,   0);
    chk("format_checked", checked_count, 2);

    // Stop on error: response 2 corrupted (expected 0x0108_0000_0000_0108).
    pulse_init();
    data_seed     = '0;
    stop_on_error = 1'b1;
    tick();
    push_addr(48'h100);
    push_addr(48'h108);
    push_addr(48'h110);
    push_addr(48'h118);
    respond('0);
    respond_data(64'h0108_0000_0000_01F7);
    tick();
    chk("stop_errors",      error_count,         1);
    chk("stop_addr",        first_error_address, 48'h108);
    chk("stop_data",        first_error_data,    64'h0108_0000_0000_01F7);
    chk("stop_halted",      halted,              1);
    chk("stop_req_ready",   bus.request_ready,   0);
    chk("stop_rsp_ready",   bus.response_ready,  0);
    chk("stop_outstanding", outstanding_count,   2);
    pulse_init();
    chk("init_halted",      halted,              0);
    chk("init_outstanding", outstanding_count,   0);
    chk("init_errors",      error_count,         0);
    chk("init_errvalid",    first_error_valid,   0);
    chk("init_req_ready",   bus.request_ready,   0);
    stop_on_error = 1'b0;

    // Continue on error: responses 2 and 3 corrupted.
    tick();
    push_addr(48'h200);
    push_addr(48'h208);
    push_addr(48'h210);
    push_addr(48'h218);
    respond('0);
    respond(64'h8000_0000_0000_0000);
    respond(64'h1);
    respond('0);
    tick();
    chk("cont_errors",  error_count,         2);
    chk("cont_checked", checked_count,       4);
    chk("cont_addr",    first_error_address, 48'h208);
    chk("cont_data",    first_error_data,    64'h8208_0000_0000_0208);
    chk("cont_halted",  halted,              0);

    // Full FIFO, then simultaneous push/pop across pointer wrap.
    pulse_init();
    tick();
    for (int i = 0; i < DEPTH; i++) push_addr(48'h1000 + 48'(8 * i));
    chk("full_req_ready",   bus.request_ready, 0);
    chk("full_outstanding", outstanding_count, 16);
    respond('0);
    chk("full_after_pop", outstanding_count, 15);
    for (int i = 0; i < 40; i++) push_pop(48'h2000 + 48'(8 * i));
    chk("wrap_outstanding", outstanding_count, 15);
    repeat (15) respond('0);
    tick();
    chk("wrap_errors",  error_count,   0);
    chk("wrap_checked", checked_count, 56);

    // Disable with entries outstanding, then re-enable and drain.
    pulse_init();
    tick();
    push_addr(48'h3000);
    push_addr(48'h3008);
    push_addr(48'h3010);
    enable = 1'b0;
    tick();
    tick();
    chk("dis_req_ready",   bus.request_ready,  0);
    chk("dis_rsp_ready",   bus.response_ready, 0);
    chk("dis_outstanding", outstanding_count,  3);
    enable = 1'b1;
    tick();
    repeat (3) respond('0);
    tick();
    chk("dis_errors",  error_count,   0);
    chk("dis_checked", checked_count, 3);

    // Reset mid-stream.
    push_addr(48'h4000);
    push_addr(48'h4008);
    respond(64'h1);
    resetn = 1'b0;
    drv_q.delete();
    #1;
    chk("rst_outstanding", outstanding_count,   0);
    chk("rst_checked",     checked_count,       0);
    chk("rst_errors",      error_count,         0);
    chk("rst_errvalid",    first_error_valid,   0);
    chk("rst_addr",        first_error_address, 0);
    chk("rst_data",        first_error_data,    0);
    chk("rst_req_ready",   bus.request_ready,   0);
    tick();
    resetn = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_read_response_checker
`default_nettype wire
